// File: rtl/alu_if.sv
// alu_if: handshake bundle between the execute-stage issue logic and alu_pipe.
//   in_*  : operation request (valid/ready), opcode, operands, set_cc, tag
//   out_* : result (valid/ready), tag, per-result flags
//   cc_*  : architectural condition codes
// master = producer/consumer side, slave = alu_pipe.
interface alu_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_set_cc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zf, out_sf, out_of, out_cf;
  logic             cc_zf, cc_sf, cc_of;

  modport master (
    output in_valid, in_op, in_a, in_b, in_set_cc, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag,
           out_zf, out_sf, out_of, out_cf, cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_set_cc, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag,
           out_zf, out_sf, out_of, out_cf, cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU (add/sub/and/xor/or/shl/shr/sar) with
// valid/ready on both sides, per-result ZF/SF/OF/CF and an optional
// architectural condition-code register.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (overrides flush and handshakes)
//   flush : synchronous kill of both stages; blocks input, voids CC update
//   io    : alu_if.slave (request, result, flags, cc_*)
// Build option: define ALU_CC_EN to build the CC register; otherwise cc_*
// are tied to 0 and in_set_cc is ignored.
module alu_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  alu_if.slave  io
);
  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_XOR = 3'd3,
    OP_OR  = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_SAR = 3'd7
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             set_cc;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    logic             zf, sf, of, cf;
    logic             set_cc;
  } rsp_t;

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;
  req_t s1_q;
  rsp_t s2_q;

  assign s2_adv      = !s2_valid || io.out_ready;
  assign s1_adv      = !s1_valid || s2_adv;
  assign io.in_ready = s1_adv && !flush;

  // ---- S2 combinational datapath ----
  logic [WIDTH:0]   add_w, sub_w;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] res;
  logic             of_c, cf_c;

  assign add_w = {1'b0, s1_q.a} + {1'b0, s1_q.b};
  assign sub_w = {1'b0, s1_q.a} - {1'b0, s1_q.b};  // bit WIDTH = borrow (A < B unsigned)
  assign shamt = s1_q.b[SH_W-1:0];

  always_comb begin
    res  = '0;
    of_c = 1'b0;
    cf_c = 1'b0;
    case (s1_q.op)
      OP_ADD: begin
        res  = add_w[WIDTH-1:0];
        cf_c = add_w[WIDTH];
        of_c = (s1_q.a[MSB] == s1_q.b[MSB]) && (add_w[MSB] != s1_q.a[MSB]);
      end
      OP_SUB: begin
        res  = sub_w[WIDTH-1:0];
        cf_c = sub_w[WIDTH];
        of_c = (s1_q.a[MSB] != s1_q.b[MSB]) && (sub_w[MSB] != s1_q.a[MSB]);
      end
      OP_AND: res = s1_q.a & s1_q.b;
      OP_XOR: res = s1_q.a ^ s1_q.b;
      OP_OR:  res = s1_q.a | s1_q.b;
      OP_SHL: res = s1_q.a << shamt;
      OP_SHR: res = s1_q.a >> shamt;
      OP_SAR: res = $signed(s1_q.a) >>> shamt;
      default: res = '0;
    endcase
  end

  // ---- pipeline registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= io.in_valid;
        if (io.in_valid)
          s1_q <= '{op: op_e'(io.in_op), a: io.in_a, b: io.in_b,
                    set_cc: io.in_set_cc, tag: io.in_tag};
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        // Result regs load only with a real op so idle cycles keep the
        // last result visible rather than garbage.
        if (s1_valid)
          s2_q <= '{result: res, tag: s1_q.tag, zf: (res == '0), sf: res[MSB],
                    of: of_c, cf: cf_c, set_cc: s1_q.set_cc};
      end
    end
  end

  assign io.out_valid  = s2_valid;
  assign io.out_result = s2_q.result;
  assign io.out_tag    = s2_q.tag;
  assign io.out_zf     = s2_q.zf;
  assign io.out_sf     = s2_q.sf;
  assign io.out_of     = s2_q.of;
  assign io.out_cf     = s2_q.cf;

`ifdef ALU_CC_EN
  logic [2:0] cc_q;  // {zf, sf, of}

  // Retirement is the output handshake; a flush in the same cycle voids it.
  always_ff @(posedge clk) begin
    if (rst)
      cc_q <= 3'b100;
    else if (!flush && s2_valid && io.out_ready && s2_q.set_cc)
      cc_q <= {s2_q.zf, s2_q.sf, s2_q.of};
  end

  assign io.cc_zf = cc_q[2];
  assign io.cc_sf = cc_q[1];
  assign io.cc_of = cc_q[0];
`else
  logic unused_set_cc;
  assign unused_set_cc = s2_q.set_cc;
  assign io.cc_zf = 1'b0;
  assign io.cc_sf = 1'b0;
  assign io.cc_of = 1'b0;
`endif
endmodule
